// File: rtl/uart_pkg.sv
// Shared constants for the UART command-frame parser: header bytes, frame
// length, FSM state encoding and the inter-byte timeout limit helper.
package uart_pkg;

  localparam logic [7:0] HDR0      = 8'h55;
  localparam logic [7:0] HDR1      = 8'hAA;
  localparam int         FRAME_LEN = 7;
  localparam int         TO_W      = 24;

  typedef enum logic [2:0] {
    ST_HUNT0 = 3'd0,
    ST_HUNT1 = 3'd1,
    ST_CMD   = 3'd2,
    ST_ADDR  = 3'd3,
    ST_DATH  = 3'd4,
    ST_DATL  = 3'd5,
    ST_CHK   = 3'd6
  } state_t;

  // Last counter value that is still inside the allowed inter-byte gap.
  function automatic logic [TO_W-1:0] calc_to_max(input int clk_freq, input int bps,
                                                  input int bits);
    return TO_W'((clk_freq / bps) * bits - 1);
  endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Parses 55 AA CMD ADDR DATA_H DATA_L CHK frames from a UART receiver, checks the
// additive checksum and aborts a frame when the line stalls between bytes.
//
// state | meaning
// HUNT0 | idle, waiting for header byte 0x55
// HUNT1 | 0x55 seen, waiting for 0xAA
// CMD   | next byte is the command
// ADDR  | next byte is the address
// DATH  | next byte is data high
// DATL  | next byte is data low
// CHK   | next byte is the checksum
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int UART_BPS     = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        cmd_valid,
  output logic [7:0]  cmd,
  output logic [7:0]  addr,
  output logic [15:0] data,
  output logic        chk_err,
  output logic        timeout_err
);

  localparam logic [TO_W-1:0] TO_MAX = calc_to_max(CLK_FREQ, UART_BPS, TIMEOUT_BITS);

  state_t          state_q, state_d;
  logic            rx_done_q;
  logic            armed_q, armed_d;
  logic [7:0]      sum_q, sum_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      sh_cmd_q, sh_cmd_d;
  logic [7:0]      sh_addr_q, sh_addr_d;
  logic [7:0]      sh_dath_q, sh_dath_d;
  logic [7:0]      sh_datl_q, sh_datl_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      addr_q, addr_d;
  logic [15:0]     data_q, data_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            chk_err_q, chk_err_d;
  logic            timeout_err_q, timeout_err_d;
  logic            byte_stb;
  logic            timeout_hit;

  // armed_q stays low until rx_done has been seen low, so a level already high
  // when reset releases is not mistaken for a fresh byte.
  assign armed_d     = armed_q | ~rx_done;
  assign byte_stb    = rx_done & ~rx_done_q & armed_q;
  assign timeout_hit = (to_cnt_q == TO_MAX) & ~byte_stb & (state_q != ST_HUNT0);

  always_comb begin
    state_d       = state_q;
    sum_d         = sum_q;
    sh_cmd_d      = sh_cmd_q;
    sh_addr_d     = sh_addr_q;
    sh_dath_d     = sh_dath_q;
    sh_datl_d     = sh_datl_q;
    cmd_d         = cmd_q;
    addr_d        = addr_q;
    data_d        = data_q;
    cmd_valid_d   = 1'b0;
    chk_err_d     = 1'b0;
    timeout_err_d = 1'b0;

    if (byte_stb || timeout_hit || (state_q == ST_HUNT0)) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
    end

    if (timeout_hit) begin
      state_d       = ST_HUNT0;
      timeout_err_d = 1'b1;
      sum_d         = '0;
      sh_cmd_d      = '0;
      sh_addr_d     = '0;
      sh_dath_d     = '0;
      sh_datl_d     = '0;
    end else if (byte_stb) begin
      case (state_q)
        ST_HUNT0: begin
          if (rx_data == HDR0) state_d = ST_HUNT1;
        end
        ST_HUNT1: begin
          if (rx_data == HDR1) begin
            state_d = ST_CMD;
            sum_d   = '0;
          end else if (rx_data != HDR0) begin
            state_d = ST_HUNT0;
          end
        end
        ST_CMD: begin
          sh_cmd_d = rx_data;
          sum_d    = sum_q + rx_data;
          state_d  = ST_ADDR;
        end
        ST_ADDR: begin
          sh_addr_d = rx_data;
          sum_d     = sum_q + rx_data;
          state_d   = ST_DATH;
        end
        ST_DATH: begin
          sh_dath_d = rx_data;
          sum_d     = sum_q + rx_data;
          state_d   = ST_DATL;
        end
        ST_DATL: begin
          sh_datl_d = rx_data;
          sum_d     = sum_q + rx_data;
          state_d   = ST_CHK;
        end
        ST_CHK: begin
          if (rx_data == sum_q) begin
            cmd_d       = sh_cmd_q;
            addr_d      = sh_addr_q;
            data_d      = {sh_dath_q, sh_datl_q};
            cmd_valid_d = 1'b1;
          end else begin
            chk_err_d = 1'b1;
          end
          state_d = ST_HUNT0;
        end
        default: state_d = ST_HUNT0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_HUNT0;
      rx_done_q     <= 1'b0;
      armed_q       <= 1'b0;
      sum_q         <= '0;
      to_cnt_q      <= '0;
      sh_cmd_q      <= '0;
      sh_addr_q     <= '0;
      sh_dath_q     <= '0;
      sh_datl_q     <= '0;
      cmd_q         <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      cmd_valid_q   <= 1'b0;
      chk_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_done_q     <= rx_done;
      armed_q       <= armed_d;
      sum_q         <= sum_d;
      to_cnt_q      <= to_cnt_d;
      sh_cmd_q      <= sh_cmd_d;
      sh_addr_q     <= sh_addr_d;
      sh_dath_q     <= sh_dath_d;
      sh_datl_q     <= sh_datl_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      cmd_valid_q   <= cmd_valid_d;
      chk_err_q     <= chk_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign cmd         = cmd_q;
  assign addr        = addr_q;
  assign data        = data_q;
  assign cmd_valid   = cmd_valid_q;
  assign chk_err     = chk_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: table of frames, randomized byte streams against a
// frame-level reference model, and directed timeout / reset sequences.
module tb_uart_cmd_parser;
  import uart_pkg::*;

  localparam int TO_LIMIT = (50_000_000 / 115200) * 20 - 1;
  localparam logic [2:0] EV_VALID = 3'b100;
  localparam logic [2:0] EV_CHK   = 3'b010;
  localparam logic [2:0] EV_TO    = 3'b001;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        cmd_valid, chk_err, timeout_err;
  logic [7:0]  cmd, addr;
  logic [15:0] data;

  uart_cmd_parser dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .cmd_valid(cmd_valid), .cmd(cmd), .addr(addr), .data(data),
    .chk_err(chk_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  kind;
    int          at;
    logic [7:0]  c;
    logic [7:0]  a;
    logic [15:0] d;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  n_cmp = 0, n_fail = 0;
  int  n_valid = 0, n_chk = 0, n_to = 0;

  always @(negedge clk) begin
    ev_t e;
    if (cmd_valid | chk_err | timeout_err) begin
      e.kind = {cmd_valid, chk_err, timeout_err};
      e.at = cyc; e.c = cmd; e.a = addr; e.d = data;
      obs_q.push_back(e);
      if (cmd_valid) n_valid++;
      if (chk_err) n_chk++;
      if (timeout_err) n_to++;
    end
  end

  // Reference model: bytes collected since the header, frame-level rules only.
  logic [7:0]  m_frame[$];
  int          m_last = 0;
  logic [7:0]  m_cmd = 8'h00, m_addr = 8'h00;
  logic [15:0] m_data = 16'h0000;

  task automatic model_gap(input int now);
    if (m_frame.size() > 0 && now - m_last > TO_LIMIT + 1) begin
      exp_q.push_back('{EV_TO, m_last + TO_LIMIT + 2, m_cmd, m_addr, m_data});
      m_frame.delete();
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input int now);
    logic [7:0] s;
    model_gap(now);
    if (m_frame.size() == 0) begin
      if (b == 8'h55) m_frame.push_back(b);
    end else if (m_frame.size() == 1 && b != 8'hAA) begin
      if (b != 8'h55) m_frame.delete();
    end else begin
      m_frame.push_back(b);
      if (m_frame.size() == FRAME_LEN) begin
        s = m_frame[2] + m_frame[3] + m_frame[4] + m_frame[5];
        if (s == m_frame[6]) begin
          m_cmd  = m_frame[2];
          m_addr = m_frame[3];
          m_data = {m_frame[4], m_frame[5]};
          exp_q.push_back('{EV_VALID, now + 1, m_cmd, m_addr, m_data});
        end else begin
          exp_q.push_back('{EV_CHK, now + 1, m_cmd, m_addr, m_data});
        end
        m_frame.delete();
      end
    end
    m_last = now;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    model_byte(b, cyc);
    repeat (hold) @(posedge clk);
    #1 rx_done = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_r(input logic [7:0] b);
    send_byte(b, 1 + int'($urandom_range(0, 2)), int'($urandom_range(0, 5)));
  endtask

  task automatic checkpoint(input string name);
    ev_t e, o;
    repeat (4) @(posedge clk);
    @(negedge clk);
    model_gap(cyc);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o.kind !== e.kind || o.at != e.at || o.c !== e.c || o.a !== e.a || o.d !== e.d) begin
        n_fail++;
        $display("FAIL %s event: got kind=%b cyc=%0d out=%h/%h/%h, want kind=%b cyc=%0d out=%h/%h/%h",
                 name, o.kind, o.at, o.c, o.a, o.d, e.kind, e.at, e.c, e.a, e.d);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s event count: %0d unmatched observed, %0d unmatched expected",
               name, obs_q.size(), exp_q.size());
      exp_q.delete();
      obs_q.delete();
    end
    n_cmp++;
    if ({cmd, addr, data} !== {m_cmd, m_addr, m_data}) begin
      n_fail++;
      $display("FAIL %s outputs: got %h/%h/%h, want %h/%h/%h",
               name, cmd, addr, data, m_cmd, m_addr, m_data);
    end
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if ({cmd, addr, data, cmd_valid, chk_err, timeout_err} !== 35'd0) begin
      n_fail++;
      $display("FAIL %s reset values: got %h/%h/%h pulses=%b%b%b, want all zero",
               name, cmd, addr, data, cmd_valid, chk_err, timeout_err);
    end
  endtask

  task automatic do_reset(input int cycles, input string name);
    @(posedge clk); #1 rst = 1'b1;
    m_frame.delete();
    m_cmd = 8'h00; m_addr = 8'h00; m_data = 16'h0000;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check_zero(name);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  b[9];
    int          n;
    int          nv;
    int          nc;
    logic [7:0]  c;
    logic [7:0]  a;
    logic [15:0] d;
  } vec_t;

  vec_t       vt[8];
  int         v0, c0;
  logic [7:0] pl[4];
  logic [7:0] ck;
  int         kind, nb;

  initial begin
    vt[0] = '{'{8'h55,8'hAA,8'h01,8'h10,8'h12,8'h34,8'h57,8'h00,8'h00}, 7, 1, 0, 8'h01, 8'h10, 16'h1234};
    vt[1] = '{'{8'h55,8'hAA,8'h01,8'h10,8'h12,8'h34,8'h58,8'h00,8'h00}, 7, 0, 1, 8'h01, 8'h10, 16'h1234};
    vt[2] = '{'{8'h55,8'h55,8'hAA,8'h02,8'h20,8'h00,8'hFF,8'h21,8'h00}, 8, 1, 0, 8'h02, 8'h20, 16'h00FF};
    vt[3] = '{'{8'h00,8'h55,8'hAA,8'hFF,8'hFF,8'hFF,8'hFF,8'hFC,8'h00}, 8, 1, 0, 8'hFF, 8'hFF, 16'hFFFF};
    vt[4] = '{'{8'h55,8'h13,8'h55,8'hAA,8'h80,8'h80,8'h00,8'h01,8'h01}, 9, 1, 0, 8'h80, 8'h80, 16'h0001};
    vt[5] = '{'{8'h55,8'hAA,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 7, 1, 0, 8'h00, 8'h00, 16'h0000};
    vt[6] = '{'{8'hAA,8'h55,8'hAA,8'h10,8'h20,8'h30,8'h40,8'hA0,8'h00}, 8, 1, 0, 8'h10, 8'h20, 16'h3040};
    vt[7] = '{'{8'h55,8'hAA,8'h03,8'h04,8'h05,8'h06,8'h00,8'h00,8'h00}, 7, 0, 1, 8'h10, 8'h20, 16'h3040};

    rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("power-on");
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      v0 = n_valid; c0 = n_chk;
      for (int k = 0; k < vt[i].n; k++)
        send_byte(vt[i].b[k], 1 + int'($urandom_range(0, 2)), int'($urandom_range(0, 4)));
      checkpoint($sformatf("vec%0d", i));
      n_cmp++;
      if (n_valid - v0 != vt[i].nv || n_chk - c0 != vt[i].nc ||
          {cmd, addr, data} !== {vt[i].c, vt[i].a, vt[i].d}) begin
        n_fail++;
        $display("FAIL vec%0d table: got valid=%0d chk=%0d out=%h/%h/%h, want valid=%0d chk=%0d out=%h/%h/%h",
                 i, n_valid - v0, n_chk - c0, cmd, addr, data,
                 vt[i].nv, vt[i].nc, vt[i].c, vt[i].a, vt[i].d);
      end
    end

    // rx_done held high for a full bit-time-scale window per byte
    for (int k = 0; k < FRAME_LEN; k++) begin
      case (k)
        0: send_byte(8'h55, 434, 433);
        1: send_byte(8'hAA, 434, 433);
        2: send_byte(8'h0A, 434, 433);
        3: send_byte(8'h0B, 434, 433);
        4: send_byte(8'h0C, 434, 433);
        5: send_byte(8'h0D, 434, 433);
        default: send_byte(8'h3A, 434, 433);
      endcase
    end
    checkpoint("long-hold");

    for (int f = 0; f < 60; f++) begin
      kind = int'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) pl[k] = 8'($urandom);
      ck = pl[0] + pl[1] + pl[2] + pl[3];
      case (kind)
        0, 1: begin
          send_r(8'h55); send_r(8'hAA);
          for (int k = 0; k < 4; k++) send_r(pl[k]);
          send_r(kind == 1 ? ck + 8'd1 : ck);
        end
        2: begin
          nb = int'($urandom_range(1, 5));
          for (int k = 0; k < nb; k++) begin
            case ($urandom_range(0, 2))
              0: send_r(8'h55);
              1: send_r(8'hAA);
              default: send_r(8'($urandom));
            endcase
          end
        end
        default: begin
          send_r(8'h55); send_r(8'hAA);
          nb = int'($urandom_range(0, 3));
          for (int k = 0; k < nb; k++) send_r(pl[k]);
        end
      endcase
    end
    checkpoint("random");

    do_reset(3, "reset-idle");
    send_byte(8'h55, 1, 2); send_byte(8'hAA, 1, 2); send_byte(8'h01, 1, 2);
    send_byte(8'h10, 1, 2); send_byte(8'h12, 1, 2);
    checkpoint("pre-abort");
    rx_data = 8'h55; rx_done = 1'b1;
    do_reset(2, "reset-mid-frame");
    repeat (5) @(posedge clk);
    #1 rx_done = 1'b0;
    send_byte(8'hAA, 1, 2); send_byte(8'h07, 1, 2); send_byte(8'h08, 1, 2);
    send_byte(8'h09, 1, 2); send_byte(8'h0A, 1, 2); send_byte(8'h22, 1, 2);
    checkpoint("after-reset-high");
    send_byte(8'h55, 1, 2); send_byte(8'hAA, 1, 2); send_byte(8'h07, 1, 2);
    send_byte(8'h08, 1, 2); send_byte(8'h09, 1, 2); send_byte(8'h0A, 1, 2);
    send_byte(8'h22, 1, 2);
    checkpoint("after-reset-frame");

    // long gap after CMD, then a complete frame
    send_byte(8'h55, 1, 2); send_byte(8'hAA, 1, 2); send_byte(8'h01, 1, 9000);
    for (int k = 0; k < FRAME_LEN; k++) send_byte(vt[0].b[k], 1, 2);
    checkpoint("timeout-cmd");

    // byte arriving exactly on the timeout cycle is taken
    send_byte(8'h55, 1, 2); send_byte(8'hAA, 1, 2); send_byte(8'h01, 1, TO_LIMIT - 1);
    send_byte(8'h10, 1, 2); send_byte(8'h12, 1, 2); send_byte(8'h34, 1, 2);
    send_byte(8'h57, 1, 2);
    checkpoint("timeout-tie");

    // one cycle later the frame is dropped
    send_byte(8'h55, 1, 2); send_byte(8'hAA, 1, 2); send_byte(8'h01, 1, TO_LIMIT);
    send_byte(8'h10, 1, 2); send_byte(8'h12, 1, 2); send_byte(8'h34, 1, 2);
    send_byte(8'h57, 1, 2);
    checkpoint("timeout-plus1");

    send_byte(8'h55, 1, 9000); send_byte(8'hAA, 1, 2);
    for (int k = 0; k < FRAME_LEN; k++) send_byte(vt[5].b[k], 1, 2);
    checkpoint("timeout-hunt1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 115200, line baud rate.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 20, allowed inter-byte gap in bit times.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port rx_data, input, 8, received byte from the upstream UART receiver.
REQ-007 SHALL have port rx_done, input, 1, byte-ready level; may stay high for many cycles per byte.
REQ-008 SHALL have port cmd_valid, output, 1, one-cycle pulse when a frame has been accepted.
REQ-009 SHALL have port cmd, output, 8, command byte of the last accepted frame.
REQ-010 SHALL have port addr, output, 8, address byte of the last accepted frame.
REQ-011 SHALL have port data, output, 16, data word {DATA_H,DATA_L} of the last accepted frame.
REQ-012 SHALL have port chk_err, output, 1, one-cycle pulse on checksum mismatch.
REQ-013 SHALL have port timeout_err, output, 1, one-cycle pulse on inter-byte timeout.

Function
REQ-014 SHALL define the frame as 0x55, 0xAA, CMD, ADDR, DATA_H, DATA_L, CHK.
REQ-015 SHALL register rx_done once and form byte_stb = rx_done & ~rx_done_q, so exactly one byte is taken per rx_done rising edge.
REQ-016 SHALL sample rx_data in the byte_stb cycle.
REQ-017 SHALL implement states HUNT0, HUNT1, CMD, ADDR, DATH, DATL, CHK; it SHALL leave a state only on byte_stb, timeout or reset.
REQ-018 HUNT0: on 0x55, go to HUNT1; on any other byte, stay in HUNT0.
REQ-019 HUNT1: on 0xAA, go to CMD; on 0x55, stay in HUNT1; on any other byte, go to HUNT0.
REQ-020 CMD, ADDR, DATH and DATL SHALL each capture their byte into a shadow register and advance to the next state.
REQ-021 SHALL keep an 8-bit checksum, cleared on entering CMD, that adds each of CMD, ADDR, DATA_H and DATA_L modulo 256 (carries discarded).
REQ-022 CHK state: if the received byte equals the checksum, the shadow registers SHALL be copied to cmd/addr/data and cmd_valid SHALL pulse; otherwise chk_err SHALL pulse and cmd/addr/data SHALL hold. In both cases the next state is HUNT0.
REQ-023 cmd_valid and chk_err SHALL be registered and assert in the cycle after the CHK byte_stb cycle; cmd/addr/data SHALL update on the same edge.
REQ-024 SHALL run a timeout counter with limit TO_MAX = (CLK_FREQ/UART_BPS)*TIMEOUT_BITS - 1, 24-bit wide.
REQ-025 The timeout counter SHALL be cleared on byte_stb and while in HUNT0, and SHALL increment otherwise.
REQ-026 When the timeout counter reaches TO_MAX and there is no byte_stb, the block SHALL go to HUNT0, pulse timeout_err on the next cycle and discard the shadow registers.
REQ-027 On simultaneous byte_stb and timeout, byte_stb SHALL win: the byte is processed normally and no timeout_err is raised.
REQ-028 cmd_valid, chk_err and timeout_err SHALL be mutually exclusive and never high for more than one cycle.

Reset
REQ-029 On rst, state SHALL be HUNT0 and the checksum, timeout counter, shadow registers and rx_done_q SHALL be 0.
REQ-030 On rst, cmd=0, addr=0, data=0 and cmd_valid=chk_err=timeout_err=0; assertion mid-frame SHALL abandon the frame with no error pulse.
REQ-031 After rst deasserts while rx_done is high, that level SHALL NOT produce a byte_stb.

Structure
REQ-032 SHALL place constants in the shared package uart_pkg: the header bytes 0x55/0xAA, the state encodings and the frame length.
REQ-033 SHALL use no sub-module; edge detect, FSM, checksum and timeout are inline. The upstream uart_rx instance lives in the parent.

Verification
REQ-034 Frame 55 AA 01 10 12 34 57 -> one cmd_valid pulse with cmd=01, addr=10, data=1234.
REQ-035 Frame 55 AA 01 10 12 34 58 -> one chk_err pulse; cmd/addr/data unchanged from before.
REQ-036 Bytes 55 55 AA 02 20 00 FF 21 -> cmd_valid with cmd=02, addr=20, data=00FF.
REQ-037 55 AA 01 followed by a gap of 8680+ cycles at 50 MHz/115200, then a full valid frame -> one timeout_err pulse, then one cmd_valid for the new frame.
REQ-038 rx_done held high 434 cycles per byte -> each byte counted once; rst asserted after DATH -> no pulse, next valid frame accepted.
